// File: rtl/acc_datapath_mc.sv
// acc_datapath_mc: multi-cycle accumulator datapath with a FETCH/EXEC sequencer.
// Holds pc, ir, accumulator and Z/C flags; reaches instruction and data memory
// over req/ack handshakes so slow memories simply stretch the instruction.
//
// Ports:
//   clk, reset        rising-edge clock, async active-high reset
//   run               allows the next instruction fetch (sampled in FETCH only)
//   im_req/im_abus    instruction fetch request and address (= pc)
//   im_ack/im_dbus    instruction valid / instruction word {opcode, operand}
//   dm_req/dm_we      data memory request, 1 = write (STA)
//   dm_abus           data address (= ir operand)
//   dm_in_dbus        write data (= accumulator)
//   dm_ack/dm_out_dbus read data valid or write accepted / read data
//   ac_out            accumulator
//   zero, carry       Z and C flags
//   opcode            opcode field of ir
//   instr_done        combinational pulse in the cycle an instruction retires
module acc_datapath_mc #(
    parameter int unsigned         DATA_W   = 8,
    parameter int unsigned         ADDR_W   = 5,
    parameter logic [ADDR_W-1:0]   RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    output logic                  im_req,
    output logic [ADDR_W-1:0]     im_abus,
    input  logic                  im_ack,
    input  logic [ADDR_W+2:0]     im_dbus,
    output logic                  dm_req,
    output logic                  dm_we,
    output logic [ADDR_W-1:0]     dm_abus,
    output logic [DATA_W-1:0]     dm_in_dbus,
    input  logic                  dm_ack,
    input  logic [DATA_W-1:0]     dm_out_dbus,
    output logic [DATA_W-1:0]     ac_out,
    output logic                  zero,
    output logic                  carry,
    output logic [2:0]            opcode,
    output logic                  instr_done
);

    localparam int unsigned INSTR_W = 3 + ADDR_W;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_XOR = 3'b011,
        OP_LDA = 3'b100,
        OP_STA = 3'b101,
        OP_JMP = 3'b110,
        OP_JZ  = 3'b111
    } opcode_t;

    typedef enum logic {
        S_FETCH = 1'b0,
        S_EXEC  = 1'b1
    } state_t;

    state_t              state, state_n;
    logic [ADDR_W-1:0]   pc, pc_n;
    logic [INSTR_W-1:0]  ir, ir_n;
    logic [DATA_W-1:0]   ac, ac_n;
    logic                z_flag, z_n;
    logic                c_flag, c_n;

    opcode_t             op;
    logic [ADDR_W-1:0]   operand;
    logic                is_jump;

    logic [DATA_W:0]     sum_ext;
    logic [DATA_W:0]     diff_ext;
    logic [DATA_W-1:0]   alu_res;
    logic                alu_c;
    logic                alu_wr_c;

    // Instruction field decode
    assign op      = opcode_t'(ir[INSTR_W-1 -: 3]);
    assign operand = ir[ADDR_W-1:0];
    assign is_jump = (op == OP_JMP) || (op == OP_JZ);

    // Datapath outputs follow the architectural registers directly
    assign im_abus    = pc;
    assign dm_abus    = operand;
    assign dm_in_dbus = ac;
    assign ac_out     = ac;
    assign zero       = z_flag;
    assign carry      = c_flag;
    assign opcode     = ir[INSTR_W-1 -: 3];

    // ALU: extended add/sub give carry-out and borrow in the top bit
    always_comb begin
        sum_ext  = {1'b0, ac} + {1'b0, dm_out_dbus};
        diff_ext = {1'b0, ac} - {1'b0, dm_out_dbus};
        alu_res  = dm_out_dbus;
        alu_c    = c_flag;
        alu_wr_c = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res  = sum_ext[DATA_W-1:0];
                alu_c    = sum_ext[DATA_W];
                alu_wr_c = 1'b1;
            end
            OP_SUB: begin
                alu_res  = diff_ext[DATA_W-1:0];
                alu_c    = diff_ext[DATA_W];
                alu_wr_c = 1'b1;
            end
            OP_AND:  alu_res = ac & dm_out_dbus;
            OP_XOR:  alu_res = ac ^ dm_out_dbus;
            OP_LDA:  alu_res = dm_out_dbus;
            default: alu_res = ac;
        endcase
    end

    // State and architectural registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_FETCH;
            pc     <= RESET_PC;
            ir     <= '0;
            ac     <= '0;
            z_flag <= 1'b0;
            c_flag <= 1'b0;
        end else begin
            state  <= state_n;
            pc     <= pc_n;
            ir     <= ir_n;
            ac     <= ac_n;
            z_flag <= z_n;
            c_flag <= c_n;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_n    = state;
        pc_n       = pc;
        ir_n       = ir;
        ac_n       = ac;
        z_n        = z_flag;
        c_n        = c_flag;
        im_req     = 1'b0;
        dm_req     = 1'b0;
        dm_we      = 1'b0;
        instr_done = 1'b0;

        case (state)
            S_FETCH: begin
                im_req = run;
                if (run && im_ack) begin
                    ir_n    = im_dbus;
                    pc_n    = pc + ADDR_W'(1);
                    state_n = S_EXEC;
                end
            end

            S_EXEC: begin
                if (is_jump) begin
                    // Jumps use no memory; JZ looks at Z as held entering EXEC
                    instr_done = 1'b1;
                    state_n    = S_FETCH;
                    if ((op == OP_JMP) || z_flag) begin
                        pc_n = operand;
                    end
                end else begin
                    dm_req = 1'b1;
                    dm_we  = (op == OP_STA);
                    if (dm_ack) begin
                        instr_done = 1'b1;
                        state_n    = S_FETCH;
                        if (op != OP_STA) begin
                            ac_n = alu_res;
                            z_n  = (alu_res == '0);
                            if (alu_wr_c) begin
                                c_n = alu_c;
                            end
                        end
                    end
                end
            end

            default: state_n = S_FETCH;
        endcase

        // Requests and the retire pulse drop the moment reset is asserted
        if (reset) begin
            im_req     = 1'b0;
            dm_req     = 1'b0;
            dm_we      = 1'b0;
            instr_done = 1'b0;
        end
    end

endmodule

// File: tb/tb_acc_datapath_mc.sv
// Directed bench for acc_datapath_mc (DATA_W=8, ADDR_W=5, RESET_PC=0).
// Small combinational memory models answer the handshakes; data ack latency
// is set per step by dm_lat.
module tb_acc_datapath_mc;

    logic        clk;
    logic        reset;
    logic        run;
    logic        im_req;
    logic [4:0]  im_abus;
    logic        im_ack;
    logic [7:0]  im_dbus;
    logic        dm_req;
    logic        dm_we;
    logic [4:0]  dm_abus;
    logic [7:0]  dm_in_dbus;
    logic        dm_ack;
    logic [7:0]  dm_out_dbus;
    logic [7:0]  ac_out;
    logic        zero;
    logic        carry;
    logic [2:0]  opcode;
    logic        instr_done;

    logic [7:0]  imem [32];
    logic [7:0]  dmem [32];
    int          dm_lat;
    int          dm_cnt;
    logic        im_ack_force;
    logic        dm_ack_force;

    int          errors;
    int          checks;

    acc_datapath_mc #(
        .DATA_W   (8),
        .ADDR_W   (5),
        .RESET_PC (5'd0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .im_req      (im_req),
        .im_abus     (im_abus),
        .im_ack      (im_ack),
        .im_dbus     (im_dbus),
        .dm_req      (dm_req),
        .dm_we       (dm_we),
        .dm_abus     (dm_abus),
        .dm_in_dbus  (dm_in_dbus),
        .dm_ack      (dm_ack),
        .dm_out_dbus (dm_out_dbus),
        .ac_out      (ac_out),
        .zero        (zero),
        .carry       (carry),
        .opcode      (opcode),
        .instr_done  (instr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory models
    assign im_ack      = im_req | im_ack_force;
    assign im_dbus     = imem[im_abus];
    assign dm_ack      = (dm_req && (dm_cnt == dm_lat)) | dm_ack_force;
    assign dm_out_dbus = dmem[dm_abus];

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                 dm_cnt <= 0;
        else if (!dm_req || dm_ack) dm_cnt <= 0;
        else                       dm_cnt <= dm_cnt + 1;
    end

    function automatic logic [7:0] ins(input logic [2:0] op, input logic [4:0] a);
        return {op, a};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to 2 time units after the next rising edge
    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    // Run until n instructions retire, within a cycle budget
    task automatic wait_done(input int n, input string tag);
        int seen;
        int cyc;
        seen = 0;
        cyc  = 0;
        while (seen < n && cyc < 100) begin
            next_cycle();
            if (instr_done) seen++;
            cyc++;
        end
        check(tag, 32'(seen), 32'(n));
    endtask

    initial begin
        errors       = 0;
        checks       = 0;
        reset        = 1'b1;
        run          = 1'b1;
        dm_lat       = 0;
        im_ack_force = 1'b0;
        dm_ack_force = 1'b0;
        for (int i = 0; i < 32; i++) begin
            imem[i] = 8'h00;
            dmem[i] = 8'h00;
        end
        imem[0]  = ins(3'b100, 5'd3);   // LDA 3
        imem[1]  = ins(3'b000, 5'd4);   // ADD 4
        imem[2]  = ins(3'b100, 5'd5);   // LDA 5
        imem[3]  = ins(3'b001, 5'd6);   // SUB 6
        imem[4]  = ins(3'b111, 5'd12);  // JZ 12
        imem[12] = ins(3'b100, 5'd5);   // LDA 5
        imem[13] = ins(3'b001, 5'd6);   // SUB 6
        imem[14] = ins(3'b111, 5'd20);  // JZ 20
        imem[15] = ins(3'b100, 5'd10);  // LDA 10
        imem[16] = ins(3'b101, 5'd9);   // STA 9
        imem[17] = ins(3'b110, 5'd31);  // JMP 31
        imem[31] = ins(3'b100, 5'd3);   // LDA 3
        dmem[3]  = 8'd200;
        dmem[4]  = 8'd100;
        dmem[5]  = 8'd7;
        dmem[6]  = 8'd7;
        dmem[10] = 8'h5A;

        // Reset state, with run high during reset
        next_cycle();
        next_cycle();
        check("rst_im_req",  32'(im_req), 32'd0);
        check("rst_dm_req",  32'(dm_req), 32'd0);
        check("rst_done",    32'(instr_done), 32'd0);
        check("rst_pc",      32'(im_abus), 32'd0);
        check("rst_ac",      32'(ac_out), 32'd0);
        check("rst_zc",      32'({zero, carry}), 32'd0);
        check("rst_opcode",  32'(opcode), 32'd0);
        run   = 1'b0;
        reset = 1'b0;

        // LDA 3; ADD 4 with ack every cycle
        next_cycle();
        run = 1'b1;
        #1;
        check("p1_c1_im_req", 32'(im_req), 32'd1);
        check("p1_c1_done",   32'(instr_done), 32'd0);
        next_cycle();
        check("p1_c2_done",   32'(instr_done), 32'd1);
        check("p1_c2_dm",     32'({im_req, dm_req, dm_we, dm_abus}), 32'({3'b010, 5'd3}));
        check("p1_c2_opcode", 32'(opcode), 32'd4);
        next_cycle();
        check("p1_c3_done",   32'(instr_done), 32'd0);
        check("p1_c3_ac",     32'(ac_out), 32'd200);
        check("p1_c3_pc",     32'(im_abus), 32'd1);
        next_cycle();
        check("p1_c4_done",   32'(instr_done), 32'd1);
        next_cycle();
        run = 1'b0;
        #1;
        check("p1_ac",        32'(ac_out), 32'd44);
        check("p1_zc",        32'({zero, carry}), 32'b01);
        check("p1_pc",        32'(im_abus), 32'd2);

        // Idle with run low; stray acks must be ignored
        next_cycle();
        check("idle_im_req",  32'(im_req), 32'd0);
        im_ack_force = 1'b1;
        dm_ack_force = 1'b1;
        next_cycle();
        im_ack_force = 1'b0;
        dm_ack_force = 1'b0;
        #1;
        check("stray_ack_pc", 32'(im_abus), 32'd2);
        check("stray_ack_ac", 32'(ac_out), 32'd44);
        check("stray_ack_op", 32'(opcode), 32'd0);

        // LDA 5; SUB 6 (equal); JZ 12 taken
        run = 1'b1;
        wait_done(3, "p2_retire");
        next_cycle();
        run = 1'b0;
        #1;
        check("p2_ac",  32'(ac_out), 32'd0);
        check("p2_zc",  32'({zero, carry}), 32'b10);
        check("p2_pc",  32'(im_abus), 32'd12);

        // Same program with M[6]=8: borrow, JZ not taken
        dmem[6] = 8'd8;
        run = 1'b1;
        wait_done(3, "p3_retire");
        next_cycle();
        run = 1'b0;
        #1;
        check("p3_ac",  32'(ac_out), 32'd255);
        check("p3_zc",  32'({zero, carry}), 32'b01);
        check("p3_pc",  32'(im_abus), 32'd15);

        // LDA 10 then STA 9 with a 3-cycle data ack delay
        run = 1'b1;
        wait_done(1, "p4_lda_retire");
        next_cycle();
        run = 1'b0;
        #1;
        check("p4_lda_ac", 32'(ac_out), 32'h5A);
        dm_lat = 3;
        next_cycle();
        run = 1'b1;
        #1;
        check("p4_c1_fetch", 32'({im_req, im_abus}), 32'({1'b1, 5'd16}));
        for (int c = 2; c <= 5; c++) begin
            next_cycle();
            check("p4_sta_bus", 32'({dm_req, dm_we, dm_abus, dm_in_dbus}),
                  32'({2'b11, 5'd9, 8'h5A}));
            check("p4_sta_im_req", 32'(im_req), 32'd0);
            check("p4_sta_done", 32'(instr_done), (c == 5) ? 32'd1 : 32'd0);
        end
        run = 1'b0;
        next_cycle();
        check("p4_flags", 32'({zero, carry}), 32'b01);
        check("p4_ac",    32'(ac_out), 32'h5A);
        check("p4_pc",    32'(im_abus), 32'd17);
        check("p4_idle",  32'({im_req, dm_req}), 32'd0);

        // JMP 31, then the fetch at 31 wraps pc to 0
        dm_lat = 0;
        run = 1'b1;
        wait_done(2, "p5_retire");
        next_cycle();
        run = 1'b0;
        #1;
        check("p5_pc_wrap", 32'(im_abus), 32'd0);
        check("p5_ac",      32'(ac_out), 32'd200);

        // Reset pulsed during a stalled data read
        dm_lat = 10;
        run = 1'b1;
        next_cycle();
        check("p6_stall_req", 32'(dm_req), 32'd1);
        next_cycle();
        next_cycle();
        check("p6_still_req", 32'(dm_req), 32'd1);
        reset = 1'b1;
        #1;
        check("p6_rst_dm_req", 32'(dm_req), 32'd0);
        check("p6_rst_im_req", 32'(im_req), 32'd0);
        check("p6_rst_done",   32'(instr_done), 32'd0);
        check("p6_rst_pc",     32'(im_abus), 32'd0);
        check("p6_rst_ac",     32'(ac_out), 32'd0);
        check("p6_rst_zc",     32'({zero, carry}), 32'd0);
        next_cycle();
        reset = 1'b0;
        run   = 1'b0;
        #1;
        check("p6_rel_idle", 32'(im_req), 32'd0);
        next_cycle();
        run = 1'b1;
        #1;
        check("p6_first_req", 32'({im_req, im_abus}), 32'({1'b1, 5'd0}));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
